// File: rtl/sign_apply16_pipe.sv
// Sign/magnitude to two's complement converter, two-stage valid/ready pipeline.
// The carry chain is split at N/2: stage 1 resolves the low half, stage 2 the high half.
module sign_apply16_pipe #(
  parameter int N   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [N-1:0] in_mag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
);

  localparam int H = N / 2;

  logic         v1;
  logic [H-1:0] lo1;
  logic         carry1;
  logic [H-1:0] hiX1;
  logic         ovf1;
  logic         sign1;

  logic         v2;
  logic [N-1:0] dataReg;
  logic         ovfReg;

  logic         stage2Ready;
  logic         load1;
  logic         load2;

  logic [N-1:0] xInv;
  logic [H:0]   loSum;
  logic         ovfIn;
  logic [H-1:0] hiSum;
  logic [N-1:0] wrapped;
  logic [N-1:0] satValue;
  logic [N-1:0] result;

  assign stage2Ready = !v2 || out_ready;
  assign in_ready    = !v1 || stage2Ready;
  assign load1       = in_valid && in_ready;
  assign load2       = v1 && stage2Ready;

  // Conditional invert plus the +1 of negation enters as the low-half carry-in.
  assign xInv  = in_mag ^ {N{in_sign}};
  assign loSum = {1'b0, xInv[H-1:0]} + {{H{1'b0}}, in_sign};
  assign ovfIn = (!in_sign && in_mag[N-1]) ||
                 (in_sign && in_mag[N-1] && (|in_mag[N-2:0]));

  assign hiSum    = hiX1 + {{(H-1){1'b0}}, carry1};
  assign wrapped  = {hiSum, lo1};
  assign satValue = sign1 ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign result   = (SAT && ovf1) ? satValue : wrapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      lo1    <= '0;
      carry1 <= 1'b0;
      hiX1   <= '0;
      ovf1   <= 1'b0;
      sign1  <= 1'b0;
    end else if (load1) begin
      v1     <= 1'b1;
      lo1    <= loSum[H-1:0];
      carry1 <= loSum[H];
      hiX1   <= xInv[N-1:H];
      ovf1   <= ovfIn;
      sign1  <= in_sign;
    end else if (load2) begin
      v1 <= 1'b0;
    end
  end

  // Output register holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      dataReg <= '0;
      ovfReg  <= 1'b0;
    end else if (load2) begin
      v2      <= 1'b1;
      dataReg <= result;
      ovfReg  <= ovf1;
    end else if (out_ready) begin
      v2 <= 1'b0;
    end
  end

  assign out_valid = v2;
  assign out_data  = dataReg;
  assign out_ovf   = ovfReg;

endmodule
